ram_arbiter: RTL and testbench

Two-port arbiter that shares the single 64x16 data RAM and its bidirectional data bus between the CPU load/store path (port 0) and a second requester such as a DMA or debug loader (port 1). It sits between both requesters and the RAM pins. It serialises their accesses with a three-state sequencer and returns read data and a one-cycle acknowledge to whichever requester was granted.

---
 rtl/ram_arbiter_if.sv | 35 +++
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] address_to_ram;
    logic              write_enable_to_ram;
    logic              read_enable_to_ram;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1, busy,
        output address_to_ram, write_enable_to_ram, read_enable_to_ram
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, busy,
        input  address_to_ram, write_enable_to_ram, read_enable_to_ram
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single 64x16 RAM with a shared bidirectional data bus.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    ram_arbiter_if.slave      bus,
    inout  wire  [DATA_W-1:0] data_ram
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req;
    logic              win_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Port granted most recently; resets to 1 so port 0 wins the first tie.
    logic last_q;

    always_comb begin
        win_d = 1'b0;
        if (bus.req0 && bus.req1) begin
            win_d = ~last_q;
        end else begin
            win_d = bus.req1;
        end
    end
`else
    always_comb begin
        win_d = 1'b0;
        win_d = bus.req1 & ~bus.req0;
    end
`endif

    always_comb begin
        any_req   = bus.req0 | bus.req1;
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (win_d) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            ram_we_q <= 1'b0;
            ram_re_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q  <= StAccess;
                        gnt_q    <= win_d;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        busy_q   <= 1'b1;
                        ram_we_q <= sel_we;
                        ram_re_q <= ~sel_we;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        last_q   <= win_d;
`endif
                    end
                end
                StAccess: begin
                    state_q  <= StResp;
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1_q <= data_ram;
                        end else begin
                            rdata0_q <= data_ram;
                        end
                    end
                    if (gnt_q) begin
                        ack1_q <= 1'b1;
                    end else begin
                        ack0_q <= 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bus is driven only while the registered write strobe is high.
    assign data_ram = ram_we_q ? wdata_q : {DATA_W{1'bz}};

    assign bus.ack0                = ack0_q;
    assign bus.ack1                = ack1_q;
    assign bus.rdata0              = rdata0_q;
    assign bus.rdata1              = rdata1_q;
    assign bus.busy                = busy_q;
    assign bus.address_to_ram      = addr_q;
    assign bus.write_enable_to_ram = ram_we_q;
    assign bus.read_enable_to_ram  = ram_re_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(ram_we_q && ram_re_q));
    a_ack_excl: assert property (@(posedge clk) disable iff (reset)
        !(ack0_q && ack1_q));
    a_strobe_in_access: assert property (@(posedge clk) disable iff (reset)
        (ram_we_q || ram_re_q) |-> (state_q == StAccess));

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
module tb_ram_arbiter;

    typedef struct packed {
        logic        port;
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    wire  [15:0] data_ram;
    logic [15:0] mem [64];
    exp_t        sb_q [$];
    int          compared;
    int          mismatched;
    int          cyc;
    logic        prev_strobe;

    ram_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    ram_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .data_ram (data_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.write_enable_to_ram) mem[bus.address_to_ram] <= data_ram;
    end

    assign data_ram = bus.read_enable_to_ram ? mem[bus.address_to_ram] : 16'bz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic port, input logic is_read, input logic [15:0] data);
        exp_t e;
        e.port    = port;
        e.is_read = is_read;
        e.data    = data;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per ack and checks cycle-level invariants.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ack0 || bus.ack1) begin
                chk("ack_exclusive", {31'd0, bus.ack0 && bus.ack1}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", {31'd0, bus.ack1}, 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
                    if (e.is_read) begin
                        chk("rdata", {16'd0, e.port ? bus.rdata1 : bus.rdata0}, {16'd0, e.data});
                    end
                end
            end
            if (bus.read_enable_to_ram || bus.write_enable_to_ram) begin
                chk("strobe_window",
                    {31'd0, (bus.read_enable_to_ram && bus.write_enable_to_ram) ||
                     bus.ack0 || bus.ack1 || prev_strobe}, 32'd0);
            end
            prev_strobe = bus.read_enable_to_ram || bus.write_enable_to_ram;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Single access with cycle-exact strobe and ack checks.
    task automatic access(input logic port, input logic we, input logic [5:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
        push(port, ~we, exp_rd);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("acc_addr", {26'd0, bus.address_to_ram}, {26'd0, a});
        chk("acc_we", {31'd0, bus.write_enable_to_ram}, {31'd0, we});
        chk("acc_re", {31'd0, bus.read_enable_to_ram}, {31'd0, ~we});
        chk("acc_busy", {31'd0, bus.busy}, 32'd1);
        if (we) chk("acc_bus_data", {16'd0, data_ram}, {16'd0, wd});
        @(posedge clk); #1;
        chk("resp_strobes", {30'd0, bus.read_enable_to_ram, bus.write_enable_to_ram}, 32'd0);
        chk("resp_ack", {30'd0, bus.ack1, bus.ack0}, port ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        chk("idle_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [1:0] ports;
        logic [3:0] tie_ports;
        int         last_cyc;
        int         n;
        int         nack;

        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        prev_strobe = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0101);
        mem[5] = 16'h000A;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_addr", {26'd0, bus.address_to_ram}, 32'd0);
        chk("rst_strobes", {30'd0, bus.read_enable_to_ram, bus.write_enable_to_ram}, 32'd0);
        chk("rst_rdata0", {16'd0, bus.rdata0}, 32'd0);
        chk("rst_rdata1", {16'd0, bus.rdata1}, 32'd0);

        access(1'b0, 1'b0, 6'd5, 16'h0000, 16'h000A);
        chk("rdata1_untouched", {16'd0, bus.rdata1}, 32'd0);
        access(1'b1, 1'b1, 6'h0F, 16'h1234, 16'h0000);
        chk("rdata0_after_write", {16'd0, bus.rdata0}, 32'h000A);
        chk("rdata1_after_write", {16'd0, bus.rdata1}, 32'd0);
        access(1'b0, 1'b0, 6'h0F, 16'h0000, 16'h1234);

        // Reset lands during ACCESS of a port 0 read.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd6;
        @(posedge clk); #1;
        chk("pre_rst_re", {31'd0, bus.read_enable_to_ram}, 32'd1);
        reset    = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("midrst_rdata0", {16'd0, bus.rdata0}, 32'd0);
        chk("midrst_strobes", {30'd0, bus.read_enable_to_ram, bus.write_enable_to_ram}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("postrst_busy", {31'd0, bus.busy}, 32'd0);

        // Both ports held high for four accesses.
`ifdef RAM_ARB_ROUND_ROBIN_EN
        tie_ports = 4'b1010;
`else
        tie_ports = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            push(tie_ports[k], 1'b1, tie_ports[k] ? 16'h0404 : 16'h0303);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd3;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd4;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(bus.ack0 || bus.ack1) && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) begin
                chk("tie_ack_timeout", 32'(n), 32'd0);
            end else if (k > 0) begin
                chk("tie_ack_spacing", 32'(cyc - last_cyc), 32'd3);
            end
            last_cyc = cyc;
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("tie_done_busy", {31'd0, bus.busy}, 32'd0);

        // req0 held through its ack: a second access follows immediately.
        push(1'b0, 1'b1, 16'h0808);
        push(1'b0, 1'b1, 16'h0808);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd8;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack0) nack++;
            if (nack == 2) bus.req0 = 1'b0;
        end
        chk("hold_ack_count", 32'(nack), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle_busy", {31'd0, bus.busy}, 32'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
